// File: rtl/braille_cell_driver_if.sv
// Character handshake between the classifier and the braille cell driver.
// The classifier drives valid/alpha; the driver answers with ready.
interface braille_cell_driver_if;
    logic       i_valid;
    logic [7:0] i_alpha;
    logic       o_ready;

    modport master (
        output i_valid,
        output i_alpha,
        input  o_ready
    );

    modport slave (
        input  i_valid,
        input  i_alpha,
        output o_ready
    );
endinterface

// File: rtl/braille_cell_driver.sv
// Six-dot braille cell driver: staggered raise, hold, then blank gap.
// Optional 1-entry character queue enabled by defining BRAILLE_QUEUE_EN.
module braille_cell_driver #(
    parameter int STAGGER_CYCLES = 1000,
    parameter int HOLD_CYCLES    = 50000000,
    parameter int GAP_CYCLES     = 10000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    braille_cell_driver_if.slave   in_if,
    output logic [5:0]             o_dots,
    output logic                   o_busy,
    output logic                   o_char_done,
    output logic                   o_err
);

    localparam int RAISE_LEN = 6 * STAGGER_CYCLES;
    localparam int MAX_RH    = (RAISE_LEN > HOLD_CYCLES) ? RAISE_LEN : HOLD_CYCLES;
    localparam int MAXV      = (MAX_RH > GAP_CYCLES) ? MAX_RH : GAP_CYCLES;
    localparam int CW        = $clog2(MAXV + 1);

    localparam logic [CW-1:0] S_C       = CW'(STAGGER_CYCLES);
    localparam logic [CW-1:0] RAISE_END = CW'(RAISE_LEN - 1);
    localparam logic [CW-1:0] HOLD_END  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_END   = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RAISE,
        HOLD,
        CLEAR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] bound_q, bound_d;
    logic [2:0]    slot_q, slot_d;
    logic [5:0]    pat_q, pat_d;
    logic [5:0]    dots_q, dots_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          busy;
    logic          accept;
    logic          dec_ok;
    logic [5:0]    dec_pat;
    logic          start;
    logic [5:0]    start_pat;

`ifdef BRAILLE_QUEUE_EN
    logic          qfull_q, qfull_d;
    logic [5:0]    qpat_q, qpat_d;
`endif

    // Returns {supported, pattern}; lowercase folds to uppercase.
    function automatic logic [6:0] decode(input logic [7:0] ch);
        logic [7:0] u;
        logic [6:0] r;
        u = ch;
        if (ch >= 8'h61 && ch <= 8'h7A) u = ch - 8'h20;
        case (u)
            8'h20:   r = {1'b1, 6'h00};
            8'h41:   r = {1'b1, 6'h01};
            8'h42:   r = {1'b1, 6'h03};
            8'h43:   r = {1'b1, 6'h09};
            8'h44:   r = {1'b1, 6'h19};
            8'h45:   r = {1'b1, 6'h11};
            8'h46:   r = {1'b1, 6'h0B};
            8'h47:   r = {1'b1, 6'h1B};
            8'h48:   r = {1'b1, 6'h13};
            8'h49:   r = {1'b1, 6'h0A};
            8'h4A:   r = {1'b1, 6'h1A};
            8'h4B:   r = {1'b1, 6'h05};
            8'h4C:   r = {1'b1, 6'h07};
            8'h4D:   r = {1'b1, 6'h0D};
            8'h4E:   r = {1'b1, 6'h1D};
            8'h4F:   r = {1'b1, 6'h15};
            8'h50:   r = {1'b1, 6'h0F};
            8'h51:   r = {1'b1, 6'h1F};
            8'h52:   r = {1'b1, 6'h17};
            8'h53:   r = {1'b1, 6'h0E};
            8'h54:   r = {1'b1, 6'h1E};
            8'h55:   r = {1'b1, 6'h25};
            8'h56:   r = {1'b1, 6'h27};
            8'h57:   r = {1'b1, 6'h3A};
            8'h58:   r = {1'b1, 6'h2D};
            8'h59:   r = {1'b1, 6'h3D};
            8'h5A:   r = {1'b1, 6'h35};
            default: r = 7'h00;
        endcase
        return r;
    endfunction

    function automatic logic [5:0] low_mask(input logic [2:0] k);
        logic [5:0] m;
        for (int i = 0; i < 6; i++) m[i] = (3'(i) <= k);
        return m;
    endfunction

    assign busy              = (state_q != IDLE);
    assign accept            = in_if.i_valid && in_if.o_ready;
    assign {dec_ok, dec_pat} = decode(in_if.i_alpha);

`ifdef BRAILLE_QUEUE_EN
    assign in_if.o_ready = !busy || !qfull_q;
`else
    assign in_if.o_ready = !busy;
`endif

    assign o_dots      = dots_q;
    assign o_busy      = busy;
    assign o_char_done = done_q;
    assign o_err       = err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bound_d   = bound_q;
        slot_d    = slot_q;
        pat_d     = pat_q;
        dots_d    = dots_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        start     = 1'b0;
        start_pat = '0;
`ifdef BRAILLE_QUEUE_EN
        qfull_d   = qfull_q;
        qpat_d    = qpat_q;
        if (accept && busy) begin
            if (dec_ok) begin
                qfull_d = 1'b1;
                qpat_d  = dec_pat;
            end else begin
                err_d   = 1'b1;
            end
        end
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    if (dec_ok) begin
                        start     = 1'b1;
                        start_pat = dec_pat;
                    end else begin
                        err_d     = 1'b1;
                    end
                end
            end
            RAISE: begin
                if (cnt_q == RAISE_END) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    dots_d  = pat_q;
                end else if (cnt_q == bound_q - CW'(1)) begin
                    // Next stagger slot exposes one more dot position.
                    slot_d  = slot_q + 3'd1;
                    bound_d = bound_q + S_C;
                    dots_d  = pat_q & low_mask(slot_q + 3'd1);
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_END) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    dots_d  = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == GAP_END) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
`ifdef BRAILLE_QUEUE_EN
                    // Chain straight into the next character, skipping IDLE.
                    if (qfull_q) begin
                        start     = 1'b1;
                        start_pat = qpat_q;
                        qfull_d   = 1'b0;
                    end else if (accept && dec_ok) begin
                        start     = 1'b1;
                        start_pat = dec_pat;
                        qfull_d   = 1'b0;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (start) begin
            state_d = RAISE;
            cnt_d   = '0;
            bound_d = S_C;
            slot_d  = 3'd0;
            pat_d   = start_pat;
            dots_d  = {5'b0, start_pat[0]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bound_q <= '0;
            slot_q  <= 3'd0;
            pat_q   <= 6'd0;
            dots_q  <= 6'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bound_q <= bound_d;
            slot_q  <= slot_d;
            pat_q   <= pat_d;
            dots_q  <= dots_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef BRAILLE_QUEUE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            qfull_q <= 1'b0;
            qpat_q  <= 6'd0;
        end else begin
            qfull_q <= qfull_d;
            qpat_q  <= qpat_d;
        end
    end
`endif

endmodule
